keypad_scan_ctrl: RTL and testbench

Parametrised matrix-keypad scanner that sweeps an ROWS×COLS key matrix one column at a time, debounces presses and releases, and reports each accepted key as a one-cycle strobe plus code. It keeps a shift history of the last HIST_DEPTH keys for the seven-segment display multiplexer. It replaces the fixed 4×4 scan FSM and adds a programmable settle time, multi-key arbitration, a key history and optional auto-repeat.

---
 rtl/keypad_pkg.sv | 45 ++++
 rtl/keypad_scan_ctrl_row_sync.sv | 27 ++
 rtl/keypad_scan_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding and width helpers for the keypad scanner.
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN    = 3'd0,
        VERIFY  = 3'd1,
        PRESS   = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } scan_state_t;

    // Bits needed to index n items (never less than one bit).
    function automatic int index_width(input int n);
        int w;
        if (n <= 2) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

    // Width of a key code for a rows x cols matrix.
    function automatic int code_width(input int rows, input int cols);
        return index_width(rows * cols);
    endfunction

    // Largest of three cycle counts, used to size the shared counters.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_row_sync.sv
// row_sync: two-flop synchronizer bringing the asynchronous row levels into clk.
module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture; the second stage is the only one the FSM may look at.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: sweeps a ROWS x COLS key matrix one column at a time,
// debounces press and release, strobes each accepted key code and keeps a
// short history of codes for the display multiplexer.
// Optional auto-repeat while a key stays held: define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYCLES   = 4800,
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int HIST_DEPTH      = 2,
    parameter int REPEAT_CYCLES   = 24000000
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [ROWS-1:0]                                  rowPins,
    output logic [COLS-1:0]                                  colPins,
    output logic                                             key_valid,
    output logic [code_width(ROWS, COLS)-1:0]                key_code,
    output logic [HIST_DEPTH*code_width(ROWS, COLS)-1:0]     key_history,
    output logic                                             key_held
);

    localparam int CODE_W = code_width(ROWS, COLS);
    localparam int HIST_W = HIST_DEPTH * CODE_W;
    localparam int ROW_W  = index_width(ROWS);
    localparam int COL_W  = index_width(COLS);
    // One counter width covers every timed interval so no count can wrap.
    localparam int CNT_W  = index_width(max3(SETTLE_CYCLES, DEBOUNCE_CYCLES, REPEAT_CYCLES) + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(COLS - 1);

    scan_state_t        state_r, state_s;
    logic [COL_W-1:0]   col_r, col_s;
    logic [ROW_W-1:0]   row_r, row_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [ROWS-1:0]    rs_s;
    logic               row_hit_s;
    logic               emit_s;
    logic [CODE_W-1:0]  code_s;

    logic               key_valid_r;
    logic [CODE_W-1:0]  key_code_r;
    logic [HIST_W-1:0]  key_history_r;
    logic               key_held_r;
    logic [COLS-1:0]    col_pins_r;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0]   rep_r, rep_s;
`endif

    row_sync #(.WIDTH(ROWS)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rowPins),
        .q     (rs_s)
    );

    // Lowest set row wins when several rows close on the same column.
    function automatic logic [ROW_W-1:0] lowest_row(input logic [ROWS-1:0] v);
        logic [ROW_W-1:0] idx;
        idx = {ROW_W{1'b0}};
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ROW_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign row_hit_s = rs_s[row_r];
    assign code_s    = CODE_W'(int'(row_r) * COLS + int'(col_r));

    // Next-state logic: settle/scan, debounce, press, hold and release.
    always_comb begin
        state_s = state_r;
        col_s   = col_r;
        row_s   = row_r;
        cnt_s   = cnt_r;
        emit_s  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_s   = {CNT_W{1'b0}};
`endif
        case (state_r)
            SCAN: begin
                if (cnt_r == SETTLE_LAST) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (rs_s == {ROWS{1'b0}}) begin
                        col_s = (col_r == COL_LAST) ? {COL_W{1'b0}} : col_r + COL_W'(1'b1);
                    end else begin
                        row_s   = lowest_row(rs_s);
                        state_s = VERIFY;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            VERIFY: begin
                if (!row_hit_s) begin
                    state_s = SCAN;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == DEBOUNCE_LAST) begin
                    state_s = PRESS;
                    cnt_s   = {CNT_W{1'b0}};
                    emit_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            PRESS: begin
                state_s = HOLD;
                cnt_s   = {CNT_W{1'b0}};
            end
            HOLD: begin
                cnt_s = {CNT_W{1'b0}};
                if (!row_hit_s) begin
                    state_s = RELEASE;
`ifdef KEYPAD_REPEAT_EN
                end else if (rep_r == REPEAT_LAST) begin
                    emit_s = 1'b1;
                    rep_s  = {CNT_W{1'b0}};
                end else begin
                    rep_s = rep_r + CNT_W'(1'b1);
                end
`else
                end else begin
                    state_s = HOLD;
                end
`endif
            end
            RELEASE: begin
                if (row_hit_s) begin
                    state_s = HOLD;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == DEBOUNCE_LAST) begin
                    state_s = SCAN;
                    cnt_s   = {CNT_W{1'b0}};
                    col_s   = (col_r == COL_LAST) ? {COL_W{1'b0}} : col_r + COL_W'(1'b1);
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_s = SCAN;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, column, latched row and interval counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= SCAN;
            col_r   <= {COL_W{1'b0}};
            row_r   <= {ROW_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
`ifdef KEYPAD_REPEAT_EN
            rep_r   <= {CNT_W{1'b0}};
`endif
        end else begin
            state_r <= state_s;
            col_r   <= col_s;
            row_r   <= row_s;
            cnt_r   <= cnt_s;
`ifdef KEYPAD_REPEAT_EN
            rep_r   <= rep_s;
`endif
        end
    end

    // Registered outputs; code and history change on the edge that raises key_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_valid_r   <= 1'b0;
            key_code_r    <= {CODE_W{1'b0}};
            key_history_r <= {HIST_W{1'b0}};
            key_held_r    <= 1'b0;
            col_pins_r    <= COLS'(1'b1);
        end else begin
            key_valid_r <= emit_s;
            if (emit_s) begin
                key_code_r    <= code_s;
                key_history_r <= (key_history_r << CODE_W) | HIST_W'(code_s);
            end else begin
                key_code_r    <= key_code_r;
                key_history_r <= key_history_r;
            end
            key_held_r <= (state_s == HOLD) || (state_s == RELEASE);
            col_pins_r <= COLS'(1'b1) << col_s;
        end
    end

    assign colPins     = col_pins_r;
    assign key_valid   = key_valid_r;
    assign key_code    = key_code_r;
    assign key_history = key_history_r;
    assign key_held    = key_held_r;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed scenarios plus randomized presses, checked
// every cycle against a procedural model of the scanning rules.
module tb_keypad_scan_ctrl;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int SETTLE = 4;
    localparam int DEB    = 8;
    localparam int HIST   = 2;
    localparam int REP    = 50;
    localparam int CW     = 4;
    localparam int HW     = HIST * CW;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [ROWS-1:0] rowPins;
    logic [COLS-1:0] colPins;
    logic            key_valid;
    logic [CW-1:0]   key_code;
    logic [HW-1:0]   key_history;
    logic            key_held;

    // key_mat[r][c] = 1 means the key at row r / column c is physically closed
    logic [COLS-1:0] key_mat [ROWS];

    int total = 0;
    int bad   = 0;
    int strobes   = 0;
    int last_code = 0;

    // model state
    int              m_col;
    logic [ROWS-1:0] m_s1, m_s2, m_rs;
    logic            m_abort;
    logic            exp_valid;
    logic [CW-1:0]   exp_code;
    logic [HW-1:0]   exp_hist;
    logic            exp_held;

    keypad_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_CYCLES(DEB),
        .HIST_DEPTH(HIST), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .reset(reset), .rowPins(rowPins), .colPins(colPins),
        .key_valid(key_valid), .key_code(key_code), .key_history(key_history),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    // physical matrix: a row reads high when a closed key sits on the driven column
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            rowPins[r] = |(key_mat[r] & colPins);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int lowest_set(input logic [ROWS-1:0] v);
        for (int i = 0; i < ROWS; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // one clock of the model: what the scanner sees is the matrix two edges ago
    task automatic m_tick();
        @(posedge clk or posedge reset);
        exp_valid = 1'b0;
        if (reset) begin
            m_abort = 1'b1;
        end else begin
            m_rs = m_s2;
            m_s2 = m_s1;
            for (int r = 0; r < ROWS; r++) m_s1[r] = key_mat[r][m_col];
        end
    endtask

    task automatic m_emit(input int code);
        exp_valid = 1'b1;
        exp_code  = CW'(code);
        exp_hist  = (exp_hist << CW) | HW'(code);
    endtask

    // spec rules written as nested waits: dwell, debounce, hold/release
    task automatic m_run();
        int r, hits, zeros, rep;
        bit ok, holding;
        forever begin
            for (int i = 0; i < SETTLE; i++) begin
                m_tick();
                if (m_abort) return;
            end
            if (m_rs == '0) begin
                m_col = (m_col + 1) % COLS;
                continue;
            end
            r = lowest_set(m_rs);
            hits = 0;
            ok = 1'b1;
            while (ok && hits < DEB) begin
                m_tick();
                if (m_abort) return;
                if (m_rs[r]) hits++;
                else ok = 1'b0;
            end
            if (!ok) continue;
            m_emit(r * COLS + m_col);
            m_tick();
            if (m_abort) return;
            exp_held = 1'b1;
            holding = 1'b1;
            rep = 0;
            zeros = 0;
            while (1) begin
                m_tick();
                if (m_abort) return;
                if (holding) begin
                    if (!m_rs[r]) begin
                        holding = 1'b0;
                        zeros = 0;
                    end else begin
                        rep++;
`ifdef KEYPAD_REPEAT_EN
                        if (rep == REP) begin
                            m_emit(r * COLS + m_col);
                            rep = 0;
                        end
`endif
                    end
                end else begin
                    if (m_rs[r]) begin
                        holding = 1'b1;
                        rep = 0;
                    end else begin
                        zeros++;
                        if (zeros == DEB) break;
                    end
                end
            end
            exp_held = 1'b0;
            m_col = (m_col + 1) % COLS;
        end
    endtask

    initial begin
        forever begin
            m_col = 0; m_s1 = '0; m_s2 = '0; m_rs = '0; m_abort = 1'b0;
            exp_valid = 1'b0; exp_code = '0; exp_hist = '0; exp_held = 1'b0;
            wait (reset == 1'b0);
            m_run();
        end
    end

    // cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("colPins", 32'(colPins), 32'(1) << m_col);
        chk("key_valid", 32'(key_valid), 32'(exp_valid));
        chk("key_code", 32'(key_code), 32'(exp_code));
        chk("key_history", 32'(key_history), 32'(exp_hist));
        chk("key_held", 32'(key_held), 32'(exp_held));
        if (key_valid) begin
            strobes++;
            last_code = int'(key_code);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_keys();
        for (int r = 0; r < ROWS; r++) key_mat[r] = '0;
    endtask

    initial begin
        int s0, n, r, c, dur, bnc;
        bit glitch;
        clear_keys();

        // reset values
        cycles(3);
        chk("rst_col", 32'(colPins), 32'h1);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_code", 32'(key_code), 32'h0);
        chk("rst_hist", 32'(key_history), 32'h0);
        chk("rst_held", 32'(key_held), 32'h0);
        reset = 1'b0;

        // idle sweep: four cycles per column
        s0 = strobes;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("idle_col", 32'(colPins), 32'(1) << ((k / 4) % 4));
        end
        cycles(20);
        chk("idle_strobes", strobes - s0, 0);

        // clean press row 2 / col 1
        s0 = strobes;
        key_mat[2][1] = 1'b1;
        cycles(100);
        key_mat[2][1] = 1'b0;
        n = 0;
        while (key_held && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("held_drop_bound", 32'(n < 200), 32'h1);
        chk("resume_col", 32'(colPins), 32'h4);
        cycles(40);
        chk("clean_strobes", strobes - s0, 1);
        chk("clean_code", last_code, 9);

        // bouncing key row 0 / col 3
        s0 = strobes;
        for (int i = 0; i < 40; i++) begin
            key_mat[0][3] = ((i / 3) % 2 == 0);
            @(negedge clk);
        end
        chk("bounce_strobes", strobes - s0, 0);
        key_mat[0][3] = 1'b1;
        cycles(60);
        key_mat[0][3] = 1'b0;
        cycles(60);
        chk("stable_strobes", strobes - s0, 1);
        chk("stable_code", last_code, 3);

        // history: code 5 then code 14
        key_mat[1][1] = 1'b1;
        cycles(60);
        key_mat[1][1] = 1'b0;
        cycles(60);
        key_mat[3][2] = 1'b1;
        cycles(60);
        key_mat[3][2] = 1'b0;
        cycles(60);
        chk("history", 32'(key_history), 32'h5E);

        // two rows on column 0: lowest row wins, other row ignored
        s0 = strobes;
        key_mat[1][0] = 1'b1;
        key_mat[3][0] = 1'b1;
        cycles(60);
        key_mat[3][0] = 1'b0;
        cycles(40);
        key_mat[1][0] = 1'b0;
        cycles(60);
        chk("multi_strobes", strobes - s0, 1);
        chk("multi_code", last_code, 4);

`ifdef KEYPAD_REPEAT_EN
        // 160-cycle hold of code 7 pressed as column 3 becomes driven
        n = 0;
        while (colPins != 4'b0100 && n < 100) begin @(negedge clk); n++; end
        while (colPins != 4'b1000 && n < 100) begin @(negedge clk); n++; end
        chk("rep_align_bound", 32'(n < 100), 32'h1);
        s0 = strobes;
        key_mat[1][3] = 1'b1;
        cycles(160);
        key_mat[1][3] = 1'b0;
        cycles(60);
        chk("repeat_strobes", strobes - s0, 3);
        chk("repeat_code", last_code, 7);
`endif

        // randomized presses, bounces, dropouts and extra keys
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, ROWS - 1);
            c = $urandom_range(0, COLS - 1);
            bnc = $urandom_range(0, 15);
            dur = $urandom_range(20, 90);
            glitch = ($urandom_range(0, 2) == 0);
            for (int b = 0; b < bnc; b++) begin
                key_mat[r][c] = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            if ($urandom_range(0, 3) == 0) key_mat[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
            for (int d = 0; d < dur; d++) begin
                key_mat[r][c] = !(glitch && (d == dur / 2));
                @(negedge clk);
            end
            clear_keys();
            cycles($urandom_range(5, 50));
        end
        cycles(40);

        // reset while a key is held
        key_mat[0][2] = 1'b1;
        n = 0;
        while (!key_held && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reach_bound", 32'(n < 200), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_col", 32'(colPins), 32'h1);
        chk("mid_rst_valid", 32'(key_valid), 32'h0);
        chk("mid_rst_code", 32'(key_code), 32'h0);
        chk("mid_rst_hist", 32'(key_history), 32'h0);
        chk("mid_rst_held", 32'(key_held), 32'h0);
        key_mat[0][2] = 1'b0;
        cycles(3);
        reset = 1'b0;
        cycles(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
